// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised sync FIFO family:
// read-mode constants and elaboration-time parameter checks.
package fifo_pkg;

    typedef enum int unsigned {
        FIFO_MODE_STD  = 0,
        FIFO_MODE_FWFT = 1
    } fifo_mode_e;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit thresh_ok(input int unsigned depth,
                                     input int unsigned af,
                                     input int unsigned ae);
        return (af >= 1) && (af <= depth) && (ae <= depth - 1);
    endfunction

    function automatic bit mode_ok(input int unsigned fwft);
        return (fwft == int'(FIFO_MODE_STD)) || (fwft == int'(FIFO_MODE_FWFT));
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_ram_2p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              sys_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/empty thresholds, std or FWFT read mode and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL    = (ADDR_W+1)'(AE_THRESH);

    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH) || !mode_ok(FWFT) ||
        count_width(DEPTH) != ADDR_W + 1) begin : g_param_err
        $error("sync_fifo_param: invalid parameter set");
    end

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              rd_acc;
    logic              wr_acc;

    // A write at full is only accepted when a read frees a slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_CNT);
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);

    fifo_ram_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .sys_clk (sys_clk),
        .we      (wr_acc),
        .waddr   (wr_ptr),
        .wdata   (wr_data),
        .raddr   (rd_ptr),
        .rdata   (ram_rdata)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            // New error events take priority over a simultaneous clear.
            overflow  <= (wr_en & ~wr_acc) | (overflow  & ~err_clr);
            underflow <= (rd_en & empty)   | (underflow & ~err_clr);
        end
    end

    if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft
        // Masked while empty so the output reads zero after reset.
        assign rd_data  = empty ? '0 : ram_rdata;
        assign rd_valid = ~empty;
    end else begin : g_std
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= ram_rdata;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule
